// File: rtl/secure_router_pkg.sv
// Shared types and helpers for the secure_router scheduler: FSM encoding,
// payload width and the even-parity generator.
package secure_router_pkg;

    localparam int DW = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic par_even(input logic [DW-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; the search starts at ptr and wraps 3->0.
module rr_arbiter4 (
    input  logic [0:3] req,
    input  logic [1:0] ptr,
    output logic [0:3] win,
    output logic [1:0] win_idx
);

    logic [1:0] idx;

    always_comb begin
        win_idx = ptr;
        idx     = ptr;
        // Walk from the farthest offset back to ptr so the nearest requester wins.
        for (int off = 3; off >= 0; off--) begin
            idx = ptr + 2'(off);
            if (req[idx]) begin
                win_idx = idx;
            end
        end
        win          = '0;
        win[win_idx] = |req;
    end

endmodule

// File: rtl/secure_router_sched.sv
// Round-robin scheduler sharing the secure_router datapath among four requesters:
// captures the winner, appends even parity and holds one output port valid.
module secure_router_sched
    import secure_router_pkg::state_t;
    import secure_router_pkg::IDLE;
    import secure_router_pkg::DRIVE;
    import secure_router_pkg::DONE;
    import secure_router_pkg::par_even;
#(
    parameter int NREQ = 4,
    parameter int DW   = secure_router_pkg::DW,
    parameter int TMO  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [0:NREQ-1]    req,
    input  logic [0:2*NREQ-1]  req_dst,
    input  logic [0:DW*NREQ-1] req_data,
    output logic [0:NREQ-1]    gnt,
    output logic [0:DW]        d_out0,
    output logic [0:DW]        d_out1,
    output logic [0:DW]        d_out2,
    output logic [0:DW]        d_out3,
    output logic [0:3]         d_vld,
    input  logic [0:3]         d_rdy,
    output logic               busy,
    output logic               err
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      dst_q, dst_d;
    logic [DW-1:0]   pay_q, pay_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [0:NREQ-1] gnt_q, gnt_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [0:3]      vld_q, vld_d;
    logic [0:DW]     port_q [4];
    logic [0:DW]     port_d [4];

    logic [0:3]      win;
    logic [1:0]      win_idx;

    rr_arbiter4 u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dst_d   = dst_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = DRIVE;
                    ptr_d   = win_idx + 2'd1;
                    dst_d   = req_dst[2*win_idx +: 2];
                    pay_d   = req_data[DW*win_idx +: DW];
                    gnt_d   = win;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                // Acceptance takes precedence over a coincident timeout.
                if (d_rdy[dst_q]) begin
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Outputs are decoded from the next state so they become valid on the grant edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
        assign vld_d[gi]  = (state_d == DRIVE) && (dst_d == 2'(gi));
        assign port_d[gi] = vld_d[gi] ? {pay_d, par_even(pay_d)} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            dst_q   <= '0;
            pay_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                port_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dst_q   <= dst_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            for (int i = 0; i < 4; i++) begin
                port_q[i] <= port_d[i];
            end
        end
    end

    assign gnt    = gnt_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign d_vld  = vld_q;
    assign d_out0 = port_q[0];
    assign d_out1 = port_q[1];
    assign d_out2 = port_q[2];
    assign d_out3 = port_q[3];

endmodule

// File: tb/tb_secure_router_sched.sv
// Directed bench for secure_router_sched: grants, parity, rotation, timeout and reset.
module tb_secure_router_sched;

    logic        clk;
    logic        rst_n;
    logic [0:3]  req;
    logic [0:7]  req_dst;
    logic [0:23] req_data;
    logic [0:3]  gnt;
    logic [0:6]  d_out0, d_out1, d_out2, d_out3;
    logic [0:3]  d_vld;
    logic [0:3]  d_rdy;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_dout [4];
    logic [3:0] exp_g;
    int         vcnt, ecnt, errc;

    secure_router_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_dst  (req_dst),
        .req_data (req_data),
        .gnt      (gnt),
        .d_out0   (d_out0),
        .d_out1   (d_out1),
        .d_out2   (d_out2),
        .d_out3   (d_out3),
        .d_vld    (d_vld),
        .d_rdy    (d_rdy),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] dst, input logic [5:0] data);
        req_dst[2*i +: 2]  = dst;
        req_data[6*i +: 6] = data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        d_rdy = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_dst  = '0;
        req_data = '0;
        d_rdy    = '0;
        exp_dout[0] = 7'b0000011;
        exp_dout[1] = 7'b0000110;
        exp_dout[2] = 7'b0001111;
        exp_dout[3] = 7'b1101010;

        // Reset values
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_vld", d_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_dout", {d_out0, d_out1, d_out2, d_out3}, 0);
        do_reset();
        chk("idle_busy", busy, 0);

        // Single transfer to port 2, sink ready
        set_req(0, 2'd2, 6'b101101);
        d_rdy = 4'b1111;
        req   = 4'b1000;
        tick();
        $display("txn single: gnt=%b vld=%b d_out2=%b", gnt, d_vld, d_out2);
        chk("t1_gnt", gnt, 4'b1000);
        chk("t1_vld", d_vld, 4'b0010);
        chk("t1_dout2", d_out2, 7'b1011010);
        chk("t1_busy", busy, 1);
        req = '0;
        tick();
        chk("t1_gnt_off", gnt, 0);
        chk("t1_vld_off", d_vld, 0);
        chk("t1_err", err, 0);
        chk("t1_done_busy", busy, 1);
        tick();
        chk("t1_idle_busy", busy, 0);

        // All four requesting, rotation 0,1,2,3,0 at 3-cycle spacing
        do_reset();
        set_req(0, 2'd1, 6'b000001);
        set_req(1, 2'd1, 6'b000011);
        set_req(2, 2'd1, 6'b000111);
        set_req(3, 2'd1, 6'b110101);
        d_rdy = 4'b1111;
        req   = 4'b1111;
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp_g = (c % 3 == 1) ? (4'b1000 >> ((c - 1) / 3 % 4)) : 4'b0000;
            chk($sformatf("t2_gnt_c%0d", c), gnt, exp_g);
            if (c % 3 == 1) begin
                $display("txn rr: cycle=%0d gnt=%b d_out1=%b", c, gnt, d_out1);
                chk($sformatf("t2_vld_c%0d", c), d_vld, 4'b0100);
                chk($sformatf("t2_dout1_c%0d", c), d_out1, exp_dout[(c - 1) / 3 % 4]);
            end
        end
        req = '0;
        tick();
        tick();

        // Requester 1 to port 3, sink never ready: timeout after 15 cycles
        set_req(1, 2'd3, 6'b111000);
        d_rdy = '0;
        req   = 4'b0100;
        tick();
        chk("t3_gnt", gnt, 4'b0100);
        chk("t3_dout3", d_out3, 7'b1110001);
        req  = '0;
        vcnt = (d_vld == 4'b0001) ? 1 : 0;
        ecnt = 0;
        errc = 0;
        for (int c = 1; c <= 39; c++) begin
            tick();
            if (d_vld == 4'b0001) vcnt++;
            if (err) begin
                ecnt++;
                errc = c;
            end
        end
        $display("txn timeout: vld_cycles=%0d err_pulses=%0d err_cycle=%0d", vcnt, ecnt, errc);
        chk("t3_vld_cycles", vcnt, 15);
        chk("t3_err_pulses", ecnt, 1);
        chk("t3_err_cycle", errc, 15);
        chk("t3_busy_end", busy, 0);

        // Same, but the sink accepts in the last wait cycle
        req = 4'b0100;
        tick();
        chk("t4_gnt", gnt, 4'b0100);
        req = '0;
        for (int c = 1; c <= 14; c++) tick();
        chk("t4_vld_c14", d_vld, 4'b0001);
        d_rdy = 4'b0001;
        tick();
        $display("txn late_accept: vld=%b err=%b busy=%b", d_vld, err, busy);
        chk("t4_vld_c15", d_vld, 0);
        chk("t4_err_c15", err, 0);
        chk("t4_busy_c15", busy, 1);
        tick();
        chk("t4_err_c16", err, 0);
        chk("t4_busy_c16", busy, 0);

        // Destination 1 with other sinks ready: they must be ignored
        set_req(2, 2'd1, 6'b010101);
        d_rdy = 4'b1011;
        req   = 4'b0010;
        tick();
        chk("t5_gnt", gnt, 4'b0010);
        chk("t5_dout1", d_out1, 7'b0101011);
        req  = '0;
        vcnt = (d_vld == 4'b0100) ? 1 : 0;
        errc = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (d_vld == 4'b0100) vcnt++;
            if (err) errc = c;
        end
        $display("txn ignore_rdy: vld_cycles=%0d err_cycle=%0d", vcnt, errc);
        chk("t5_vld_cycles", vcnt, 15);
        chk("t5_err_cycle", errc, 15);

        // Reset in the middle of DRIVE
        set_req(3, 2'd0, 6'b100000);
        d_rdy = '0;
        req   = 4'b0001;
        tick();
        chk("t6_vld", d_vld, 4'b1000);
        chk("t6_dout0", d_out0, 7'b1000001);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn mid_reset: vld=%b d_out0=%b busy=%b", d_vld, d_out0, busy);
        chk("t6_rst_vld", d_vld, 0);
        chk("t6_rst_dout0", d_out0, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        d_rdy = 4'b1111;
        req   = 4'b1100;
        tick();
        chk("t6_gnt_first", gnt, 4'b1000);
        chk("t6_err_after", err, 0);
        tick();
        tick();
        tick();
        chk("t6_gnt_second", gnt, 4'b0100);
        req = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
